// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 8-bit CPU: fetches opcode/immediate bytes,
// decodes them and sequences the Bmux, ALU, register file, PC and memory strobes.
module cpu_control_fsm #(
  parameter int OPW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] mem_data,
  input  logic       mem_ready,
  input  logic       zero_flag,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       imm_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       B_select,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       wb_sel,
  output logic [1:0] rd_sel,
  output logic [1:0] rs_sel,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_LD   = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_ST   = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_JZ   = OPW'(4'hB);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

  state_t         cur, nxt;
  logic [7:0]     ir;
  logic           ill_q;
  logic [OPW-1:0] op;
  logic           is_reg_alu, is_imm_form, is_ill, is_alu_form;
  logic [2:0]     dec_aop;
  logic           dec_bsel;

  assign op          = ir[7 -: OPW];
  assign is_reg_alu  = (op >= OP_ADD)  && (op <= OP_OR);
  assign is_imm_form = (op >= OP_ADDI) && (op <= OP_JZ);
  assign is_ill      = (op > OP_JZ)    && (op < OP_HALT);
  assign is_alu_form = (op >= OP_ADD)  && (op <= OP_LDI);
  assign dec_bsel    = (op >= OP_ADDI) && (op <= OP_LDI);

  always_comb begin
    dec_aop = 3'b000;
    case (op)
      OP_SUB, OP_SUBI: dec_aop = 3'b001;
      OP_AND:          dec_aop = 3'b010;
      OP_OR:           dec_aop = 3'b011;
      OP_LDI:          dec_aop = 3'b100;
      default:         dec_aop = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= S_IDLE;
      ir    <= 8'h00;
      ill_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && mem_ready) ir <= mem_data;
      if (cur == S_DECODE && is_ill)   ill_q <= 1'b1;
    end
  end

  always_comb begin
    nxt       = cur;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    imm_load  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    B_select  = 1'b0;
    alu_op    = 3'b000;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    case (cur)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT)    nxt = S_HALT;
        else if (is_reg_alu)  nxt = S_EXEC;
        else if (is_imm_form) nxt = S_IMM;
        else                  nxt = S_FETCH;  // NOP and illegal opcodes
      end
      S_IMM: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          imm_load = 1'b1;
          pc_inc   = 1'b1;
          nxt      = (op == OP_LD || op == OP_ST) ? S_MEM : S_EXEC;
        end
      end
      S_EXEC: begin
        B_select = dec_bsel;
        alu_op   = dec_aop;
        if (is_alu_form) nxt = S_WB;
        else begin
          pc_load = (op == OP_JMP) || (op == OP_JZ && zero_flag);
          nxt     = S_FETCH;
        end
      end
      S_MEM: begin
        addr_sel = 1'b1;
        mem_rd   = (op == OP_LD);
        mem_wr   = (op == OP_ST);
        if (mem_ready) nxt = (op == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        // ALU controls stay at their EXEC values while the result is written
        B_select  = dec_bsel;
        alu_op    = dec_aop;
        reg_write = 1'b1;
        wb_sel    = (op == OP_LD);
        nxt       = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_IDLE;
    endcase
  end

  assign state   = cur;
  assign illegal = ill_q;
  assign rd_sel  = ir[3:2];
  assign rs_sel  = ir[1:0];

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench for cpu_control_fsm: an instruction-level model expands each
// instruction into its expected per-cycle output trace and compares every cycle.
module tb_cpu_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready, zero_flag;
  logic [7:0] mem_data;
  logic       mem_rd, mem_wr, addr_sel, ir_load, imm_load, pc_inc, pc_load;
  logic       B_select, reg_write, wb_sel, halted, illegal;
  logic [2:0] alu_op, state;
  logic [1:0] rd_sel, rs_sel;

  cpu_control_fsm #(.OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_data(mem_data),
    .mem_ready(mem_ready), .zero_flag(zero_flag), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_load(ir_load),
    .imm_load(imm_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .B_select(B_select), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .rd_sel(rd_sel), .rs_sel(rs_sel), .halted(halted),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_ir;
  logic       m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_v();
    return {10'b0, state, mem_rd, mem_wr, addr_sel, ir_load, imm_load, pc_inc,
            pc_load, B_select, alu_op, reg_write, wb_sel, rd_sel, rs_sel,
            halted, illegal};
  endfunction

  // Expected outputs for one cycle; register fields and the sticky flag come from the model.
  function automatic logic [31:0] ev(input logic [2:0] st, input logic rd, wr, as,
                                     il, iml, pi, pl, bs, input logic [2:0] aop,
                                     input logic rw, ws);
    return {10'b0, st, rd, wr, as, il, iml, pi, pl, bs, aop, rw, ws,
            m_ir[3:2], m_ir[1:0], (st == 3'd7), m_ill};
  endfunction

  function automatic logic [2:0] aop_of(input int op);
    case (op)
      1, 5:    return 3'b000;
      2, 6:    return 3'b001;
      3:       return 3'b010;
      4:       return 3'b011;
      7:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // One clock: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input string tag, input logic rdy, input logic [7:0] d,
                     input logic z, input logic [31:0] exp);
    mem_ready = rdy;
    mem_data  = d;
    zero_flag = z;
    @(negedge clk);
    chk(tag, obs_v(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] ib, input logic [7:0] imm, input int wf,
                           input int wi, input int wm, input logic z, input bit abort);
    int op;
    bit ld, st, bs;
    op = int'(ib[7:4]);
    ld = (op == 8);
    st = (op == 9);
    for (int i = 0; i < wf; i++)
      cyc("fetch_wait", 1'b0, 8'($urandom), 1'($urandom), ev(3'd1,1,0,0,0,0,0,0,0,3'd0,0,0));
    cyc("fetch", 1'b1, ib, 1'($urandom), ev(3'd1,1,0,0,1,0,1,0,0,3'd0,0,0));
    m_ir = ib;
    cyc("decode", 1'($urandom), 8'($urandom), 1'($urandom), ev(3'd2,0,0,0,0,0,0,0,0,3'd0,0,0));
    if (op >= 12 && op <= 14) m_ill = 1'b1;
    if (op == 15) begin
      for (int i = 0; i < 4; i++) begin
        run = 1'($urandom);
        cyc("halt", 1'($urandom), 8'($urandom), 1'($urandom), ev(3'd7,0,0,0,0,0,0,0,0,3'd0,0,0));
      end
      run = 1'b1;
      return;
    end
    if (op == 0 || op >= 12) return;
    if (op >= 5) begin
      for (int i = 0; i < wi; i++)
        cyc("imm_wait", 1'b0, 8'($urandom), 1'($urandom), ev(3'd3,1,0,0,0,0,0,0,0,3'd0,0,0));
      cyc("imm", 1'b1, imm, 1'($urandom), ev(3'd3,1,0,0,0,1,1,0,0,3'd0,0,0));
    end
    if (ld || st) begin
      for (int i = 0; i < wm; i++) begin
        cyc("mem_wait", 1'b0, 8'($urandom), 1'($urandom), ev(3'd5,ld,st,1,0,0,0,0,0,3'd0,0,0));
        if (abort) begin
          rst_n = 1'b0;
          #1;
          m_ir  = 8'h00;
          m_ill = 1'b0;
          chk("async_rst_mem", obs_v(), 32'h0);
          return;
        end
      end
      cyc("mem", 1'b1, 8'($urandom), 1'($urandom), ev(3'd5,ld,st,1,0,0,0,0,0,3'd0,0,0));
      if (ld) cyc("wb_ld", 1'($urandom), 8'($urandom), 1'($urandom), ev(3'd6,0,0,0,0,0,0,0,0,3'd0,1,1));
      return;
    end
    bs = (op >= 5 && op <= 7);
    if (op <= 7) begin
      cyc("exec", 1'($urandom), 8'($urandom), 1'($urandom), ev(3'd4,0,0,0,0,0,0,0,bs,aop_of(op),0,0));
      cyc("wb", 1'($urandom), 8'($urandom), 1'($urandom), ev(3'd6,0,0,0,0,0,0,0,bs,aop_of(op),1,0));
    end else begin
      cyc("exec_jump", 1'($urandom), 8'($urandom), z,
          ev(3'd4,0,0,0,0,0,0,(op == 10) ? 1'b1 : z,0,aop_of(op),0,0));
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b0; mem_data = 8'h00; zero_flag = 1'b0;
    m_ir = 8'h00; m_ill = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", obs_v(), 32'h0);
    end
    rst_n = 1'b1;
    #1 chk("idle", obs_v(), 32'h0);
    @(posedge clk); #1;

    run_instr(8'h16, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h54, 8'h09, 0, 2, 0, 1'b0, 1'b0);
    run_instr(8'h80, 8'h20, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h90, 8'h20, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'hB0, 8'h40, 0, 0, 0, 1'b1, 1'b0);
    run_instr(8'hB0, 8'h40, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'hA0, 8'h40, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'hC0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 150; n++)
      run_instr({4'($urandom_range(0, 14)), 4'($urandom)}, 8'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom), 1'b0);
    run_instr(8'hF3, 8'h00, 1, 0, 0, 1'b0, 1'b0);

    rst_n = 1'b0;
    m_ir = 8'h00; m_ill = 1'b0;
    #1 chk("rst_from_halt", obs_v(), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("idle2", obs_v(), 32'h0);
    @(posedge clk); #1;
    run_instr(8'hC0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    run_instr(8'h80, 8'h20, 0, 0, 2, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control unit for the 8-bit CPU. It fetches instruction and immediate bytes from memory, decodes them, and sequences the datapath. On the datapath it drives the ALU B-operand mux select (`B_select`: 0 = register operand on d0, 1 = immediate on d1), the ALU operation, the register-file write, the PC and the memory strobes. It sits between the memory interface and the existing datapath blocks (Bmux, ALU, register file, PC).

## Interface
Parameters:
- `OPW`, 4: opcode field width (`ir[7:4]`).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  start execution; sampled only in IDLE.
- `mem_data`  in  8  read data from memory.
- `mem_ready`  in  1  memory access completes this cycle.
- `zero_flag`  in  1  ALU zero flag (registered in the datapath).
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = immediate register.
- `ir_load`  out  1  instruction byte captured this cycle.
- `imm_load`  out  1  immediate register loads `mem_data`.
- `pc_inc`  out  1  PC increments.
- `pc_load`  out  1  PC loads the immediate register.
- `B_select`  out  1  Bmux select: 0 = register, 1 = immediate.
- `alu_op`  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASSB.
- `reg_write`  out  1  register-file write enable.
- `wb_sel`  out  1  write-back source: 0 = ALU, 1 = `mem_data`.
- `rd_sel`  out  2  destination register, `ir[3:2]`.
- `rs_sel`  out  2  source register, `ir[1:0]`.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky: an undefined opcode was decoded.
- `state`  out  3  current state encoding, for debug.

## Operation
- The internal 8-bit `ir` loads `mem_data` when FETCH completes with `mem_ready`=1.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR: register forms.
  - 5 ADDI, 6 SUBI, 7 LDI: immediate forms.
  - 8 LD, 9 ST: memory access at the immediate address.
  - A JMP, B JZ: jump to the immediate address.
  - F HALT
  - C, D, E: illegal.
- States and encodings:
  - IDLE (0): all outputs 0. Goes to FETCH when `run`=1.
  - FETCH (1): `mem_rd`=1, `addr_sel`=0. Stays until `mem_ready`. On the `mem_ready` cycle, `ir_load`=1 and `pc_inc`=1, then goes to DECODE.
  - DECODE (2): no strobes. Next state by opcode:
    - NOP → FETCH.
    - HALT → HALT.
    - Illegal → set `illegal`, then FETCH.
    - Opcodes 1–4 → EXEC.
    - Opcodes 5–B → IMM.
  - IMM (3): `mem_rd`=1, `addr_sel`=0. Waits for `mem_ready`. On that cycle, `imm_load`=1 and `pc_inc`=1. Next state: LD/ST → MEM; all others → EXEC.
  - EXEC (4):
    - `B_select`=1 for opcodes 5, 6, 7; 0 otherwise.
    - `alu_op` comes from the opcode; LDI uses PASSB.
    - ALU ops → WB.
    - JMP: `pc_load`=1 → FETCH.
    - JZ: `pc_load`=`zero_flag` → FETCH.
  - MEM (5): `addr_sel`=1. LD drives `mem_rd`=1; ST drives `mem_wr`=1. Held until `mem_ready`. Then LD → WB and ST → FETCH.
  - WB (6): `reg_write`=1. `wb_sel`=1 for LD, 0 otherwise. Then FETCH.
  - HALT (7): `halted`=1. Stays here until reset.
- Output rules:
  - All outputs are combinational from state and `ir`.
  - `alu_op` and `B_select` are 0 outside EXEC, except in WB, which holds EXEC's values for the write-back.
  - `rd_sel`/`rs_sel` always reflect `ir`.
- `illegal` clears only on reset.
- `run` is ignored outside IDLE. The controller never returns to IDLE except through reset.

## Timing
- Async reset: the state goes to IDLE and `ir` and `illegal` clear, regardless of `clk`. Every output is 0 during and after reset until `run`.
- Deasserting `rst_n` mid-access drops `mem_rd`/`mem_wr` immediately.
- Latency with `mem_ready` tied high:

| Instruction | Cycles | States |
|---|---|---|
| Register ALU | 4 | F, D, E, W |
| ADDI/SUBI/LDI | 5 | F, D, I, E, W |
| LD | 5 | F, D, I, M, W |
| ST, JMP, JZ | 4 | ST: F, D, I, M; jumps: F, D, I, E |
| NOP / illegal | 2 | F, D |

- Each cycle with `mem_ready`=0 adds one cycle in FETCH, IMM or MEM. Strobes stay stable across wait cycles.
- `pc_inc`, `ir_load`, `imm_load` and `pc_load` are single-cycle pulses. `pc_inc` and `pc_load` are never high together.
- JZ samples `zero_flag` in EXEC only.

## Test plan
- Reset and start: hold `rst_n`=0 with `run`=1. All outputs stay 0 and `state`=0. Release reset: IDLE → FETCH on the next edge.
- Register ADD: memory supplies 0x16 with `mem_ready`=1. States run 1, 2, 4, 6. In EXEC, `B_select`=0 and `alu_op`=000. WB asserts `reg_write` with `rd_sel`=01 and `rs_sel`=10.
- ADDI with wait states: memory supplies 0x54 then 0x09. `mem_ready` is low for 2 cycles in IMM. `imm_load` pulses once, `pc_inc` pulses twice in total, and EXEC shows `B_select`=1, `alu_op`=000. Total 7 cycles.
- LD/ST: LD 0x80 then 0x20. MEM asserts `mem_rd` and `addr_sel`=1; WB asserts `wb_sel`=1. ST 0x90 then 0x20. MEM asserts `mem_wr` and returns to FETCH with no `reg_write`.
- JZ: 0xB0 then 0x40. With `zero_flag`=1, `pc_load`=1 in EXEC; with `zero_flag`=0, no `pc_load`. JMP (0xA0) always asserts `pc_load`.
- Illegal/halt/async reset: 0xC0 sets `illegal` and returns to FETCH. 0xF0 enters HALT and `halted` stays 1. Dropping `rst_n` mid-MEM clears `mem_rd`/`mem_wr` and `illegal` immediately.
